// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder sequencer: drives one external 4-bit adder stage a
// nibble per clock, LSB nibble first, and registers the full-width result.
module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [3:0]       add_A,
    output logic [3:0]       add_B,
    output logic             add_C_in,
    input  logic [3:0]       add_S,
    input  logic             add_C_out
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] op_a, op_a_d;
    logic [WIDTH-1:0] op_b, op_b_d;
    logic             carry, carry_d;
    logic [IDXW-1:0]  idx, idx_d;
    logic [WIDTH-1:0] sum, sum_d;
    logic [WIDTH-1:0] s_d;
    logic             c_out_d;
    logic             ovf_d;
    logic [31:0]      base;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            S        <= '0;
            C_out    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            op_a     <= op_a_d;
            op_b     <= op_b_d;
            carry    <= carry_d;
            idx      <= idx_d;
            sum      <= sum_d;
            S        <= s_d;
            C_out    <= c_out_d;
            overflow <= ovf_d;
            busy     <= (state_d == ST_RUN);
            done     <= (state_d == ST_DONE);
        end
    end

    // Next-state, operand capture and adder-stage drive
    always_comb begin
        state_d  = state;
        op_a_d   = op_a;
        op_b_d   = op_b;
        carry_d  = carry;
        idx_d    = idx;
        sum_d    = sum;
        s_d      = S;
        c_out_d  = C_out;
        ovf_d    = overflow;
        add_A    = 4'd0;
        add_B    = 4'd0;
        add_C_in = 1'b0;
        base     = 4 * 32'(idx);

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_a_d  = A;
                    op_b_d  = B;
                    carry_d = C_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end else if (state == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                add_A            = op_a[base +: 4];
                add_B            = op_b[base +: 4];
                add_C_in         = carry;
                sum_d[base +: 4] = add_S;
                carry_d          = add_C_out;
                idx_d            = idx + IDXW'(1);
                if (idx == LAST) begin
                    // Index parks at zero so no out-of-range select survives RUN
                    idx_d   = '0;
                    s_d     = sum_d;
                    c_out_d = add_C_out;
                    ovf_d   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                              (add_S[3] != op_a[WIDTH-1]);
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and random checks of nibble_serial_adder_ctrl at WIDTH 16, 4 and 32,
// each instance wired to a behavioural 4-bit adder stage.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // WIDTH=16 instance
    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        co16, ovf16, busy16, done16;
    logic [3:0]  add_a16, add_b16, add_s16;
    logic        add_ci16, add_co16;
    assign {add_co16, add_s16} = 5'(add_a16) + 5'(add_b16) + 5'(add_ci16);

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .C_in(cin16),
        .S(s16), .C_out(co16), .overflow(ovf16), .busy(busy16), .done(done16),
        .add_A(add_a16), .add_B(add_b16), .add_C_in(add_ci16),
        .add_S(add_s16), .add_C_out(add_co16)
    );

    // WIDTH=4 instance
    logic        start4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0, s4;
    logic        co4, ovf4, busy4, done4;
    logic [3:0]  add_a4, add_b4, add_s4;
    logic        add_ci4, add_co4;
    assign {add_co4, add_s4} = 5'(add_a4) + 5'(add_b4) + 5'(add_ci4);

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .C_in(cin4),
        .S(s4), .C_out(co4), .overflow(ovf4), .busy(busy4), .done(done4),
        .add_A(add_a4), .add_B(add_b4), .add_C_in(add_ci4),
        .add_S(add_s4), .add_C_out(add_co4)
    );

    // WIDTH=32 instance
    logic        start32 = 1'b0, cin32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic        co32, ovf32, busy32, done32;
    logic [3:0]  add_a32, add_b32, add_s32;
    logic        add_ci32, add_co32;
    assign {add_co32, add_s32} = 5'(add_a32) + 5'(add_b32) + 5'(add_ci32);

    nibble_serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32), .C_in(cin32),
        .S(s32), .C_out(co32), .overflow(ovf32), .busy(busy32), .done(done32),
        .add_A(add_a32), .add_B(add_b32), .add_C_in(add_ci32),
        .add_S(add_s32), .add_C_out(add_co32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 16-bit addition with per-cycle busy/done/add_A checks
    task automatic add16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic eco,
                         input logic eovf);
        a16 = a; b16 = b; cin16 = cin; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, " busy"}, 32'(busy16), 32'd1);
            check({tag, " done_low"}, 32'(done16), 32'd0);
            check({tag, " add_A"}, 32'(add_a16), 32'(a[4*i +: 4]));
            tick();
        end
        check({tag, " done"}, 32'(done16), 32'd1);
        check({tag, " busy_low"}, 32'(busy16), 32'd0);
        check({tag, " S"}, 32'(s16), 32'(es));
        check({tag, " C_out"}, 32'(co16), 32'(eco));
        check({tag, " overflow"}, 32'(ovf16), 32'(eovf));
        tick();
        check({tag, " done_pulse"}, 32'(done16), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] full32;
        logic [4:0]  full4;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check("rst S", 32'(s16), 32'd0);
        check("rst C_out", 32'(co16), 32'd0);
        check("rst overflow", 32'(ovf16), 32'd0);
        check("rst busy", 32'(busy16), 32'd0);
        check("rst done", 32'(done16), 32'd0);
        check("rst add_A", 32'(add_a16), 32'd0);
        rst = 1'b0;
        tick();

        add16("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        add16("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        add16("cin",     16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        add16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        add16("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Start pulsed mid-RUN with different operands is ignored
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        check("midrun S_hold", 32'(s16), 32'h0000);
        tick();
        a16 = 16'hAAAA; b16 = 16'h5555; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        tick();
        check("midrun done", 32'(done16), 32'd1);
        check("midrun S", 32'(s16), 32'h3333);
        check("midrun C_out", 32'(co16), 32'd0);
        tick();

        // Start held through done: second addition begins at DONE
        a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b0; start16 = 1'b1;
        tick();
        check("b2b S_hold", 32'(s16), 32'h3333);
        tick(); tick(); tick(); tick();
        check("b2b done1", 32'(done16), 32'd1);
        check("b2b S1", 32'(s16), 32'h1010);
        a16 = 16'h0001; b16 = 16'h7FFF;
        tick();
        start16 = 1'b0;
        check("b2b busy2", 32'(busy16), 32'd1);
        check("b2b S1_hold", 32'(s16), 32'h1010);
        tick(); tick(); tick();
        check("b2b done_early", 32'(done16), 32'd0);
        tick();
        check("b2b done2", 32'(done16), 32'd1);
        check("b2b S2", 32'(s16), 32'h8000);
        check("b2b C_out2", 32'(co16), 32'd0);
        check("b2b ovf2", 32'(ovf16), 32'd1);
        tick();

        // Reset in the second RUN cycle aborts the addition
        a16 = 16'h1111; b16 = 16'h1111; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort S", 32'(s16), 32'd0);
        check("abort C_out", 32'(co16), 32'd0);
        check("abort overflow", 32'(ovf16), 32'd0);
        check("abort busy", 32'(busy16), 32'd0);
        check("abort done", 32'(done16), 32'd0);
        check("abort add_A", 32'(add_a16), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort no_done", 32'(done16), 32'd0);
        end
        add16("fresh", 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0);

        // Random regression on WIDTH=4 and WIDTH=32 against A+B+C_in
        for (int n = 0; n < 20; n++) begin
            a4  = 4'($urandom);  b4  = 4'($urandom);  cin4  = 1'($urandom);
            a32 = $urandom;      b32 = $urandom;      cin32 = 1'($urandom);
            if (n == 0) begin
                a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0;
            end
            full4  = 5'(a4) + 5'(b4) + 5'(cin4);
            full32 = 33'(a32) + 33'(b32) + 33'(cin32);
            start4 = 1'b1; start32 = 1'b1;
            tick();
            start4 = 1'b0; start32 = 1'b0;
            check("w4 busy", 32'(busy4), 32'd1);
            tick();
            check("w4 done", 32'(done4), 32'd1);
            check("w4 S", 32'(s4), 32'(full4[3:0]));
            check("w4 C_out", 32'(co4), 32'(full4[4]));
            check("w4 overflow", 32'(ovf4),
                  32'((a4[3] == b4[3]) && (full4[3] != a4[3])));
            for (int i = 0; i < 7; i++) tick();
            check("w32 done", 32'(done32), 32'd1);
            check("w32 S", s32, full32[31:0]);
            check("w32 C_out", 32'(co32), 32'(full32[32]));
            check("w32 overflow", 32'(ovf32),
                  32'((a32[31] == b32[31]) && (full32[31] != a32[31])));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
